// File: rtl/mem_responder.sv
// Handshaked multi-cycle word memory for the MAR/MDR interface.
// A request is captured, padded with wait states, executed once, then mem_ready is held until both strobes drop.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  mem_error
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LP_WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rd;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_legal;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Upper address bits are never masked: any of them set makes the request illegal.
  assign w_legal   = (r_addr[31:ADDR_WIDTH] == '0) && !(r_rd && r_wr);
  assign w_index   = r_addr[ADDR_WIDTH-1:0];
  assign w_rd_word = r_mem[w_index];
  assign w_mem_we  = (r_state == S_ACCESS) && w_legal && r_wr;

  // Array is left uninitialised; reset only touches the control path.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_index] <= r_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (read || write) begin
            r_addr  <= address;
            r_wdata <= data_in;
            r_rd    <= read;
            r_wr    <= write;
            r_err   <= 1'b0;
            r_cnt   <= LP_WS;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (w_legal) begin
            if (r_rd) r_data_out <= w_rd_word;
          end else begin
            r_err <= 1'b1;
            if (r_rd) r_data_out <= '0;
          end
          r_ready <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!read && !write) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign mem_ready = r_ready;
  assign busy      = r_busy;
  assign mem_error = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder; two instances (WAIT_STATES=2 and 0) see the same request stream.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read, write;
  logic [31:0] address, data_in;

  logic [31:0] d0, d1;
  logic        rdy0, rdy1, busy0, busy1, err0, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) u0 (
    .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(d0), .mem_ready(rdy0), .busy(busy0), .mem_error(err0));

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u1 (
    .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(d1), .mem_ready(rdy1), .busy(busy1), .mem_error(err1));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          hold;
    logic        scramble;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " d0"}, d0, 32'h0);
    check({tag, " rdy0"}, {31'b0, rdy0}, 32'h0);
    check({tag, " busy0"}, {31'b0, busy0}, 32'h0);
    check({tag, " err0"}, {31'b0, err0}, 32'h0);
    check({tag, " d1"}, d1, 32'h0);
    check({tag, " rdy1"}, {31'b0, rdy1}, 32'h0);
    check({tag, " busy1"}, {31'b0, busy1}, 32'h0);
    check({tag, " err1"}, {31'b0, err1}, 32'h0);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    read    = v.rd;
    write   = v.wr;
    address = v.addr;
    data_in = v.wdata;
  endtask

  // Starts just before the capture edge E0 with the request already on the inputs.
  task automatic finish_txn(input string tag, input vec_t v);
    int lat0 = 0;
    int lat1 = 0;
    @(posedge clk); #1;
    check({tag, " busy0@E0"}, {31'b0, busy0}, 32'h1);
    check({tag, " busy1@E0"}, {31'b0, busy1}, 32'h1);
    if (v.scramble) begin
      address = 32'h7;
      data_in = 32'h12345678;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rdy1 && lat1 == 0) lat1 = n;
      if (rdy0) begin
        lat0 = n;
        break;
      end
    end
    check({tag, " lat0"}, 32'(lat0), 32'd4);
    check({tag, " lat1"}, 32'(lat1), 32'd2);
    check({tag, " data0"}, d0, v.exp_data);
    check({tag, " data1"}, d1, v.exp_data);
    check({tag, " err0"}, {31'b0, err0}, {31'b0, v.exp_err});
    check({tag, " err1"}, {31'b0, err1}, {31'b0, v.exp_err});
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold rdy0"}, {31'b0, rdy0}, 32'h1);
      check({tag, " hold rdy1"}, {31'b0, rdy1}, 32'h1);
      check({tag, " hold data0"}, d0, v.exp_data);
    end
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle rdy0"}, {31'b0, rdy0}, 32'h0);
    check({tag, " idle busy0"}, {31'b0, busy0}, 32'h0);
    check({tag, " idle rdy1"}, {31'b0, rdy1}, 32'h0);
    check({tag, " idle err0"}, {31'b0, err0}, {31'b0, v.exp_err});
    check({tag, " idle data0"}, d0, v.exp_data);
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    drive(v);
    finish_txn(tag, v);
  endtask

  initial begin
    vec_t v;
    int   waited;

    //             rd    wr    addr          wdata         exp_data      err  hold scr
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h1111_1111, 32'h0000_0000, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 5, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h1111_1111, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 32'h1111_1111, 1'b1, 0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0003, 32'h5555_5555, 32'h0000_0000, 1'b1, 0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h8000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'h600D_F00D, 32'h0000_0000, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h600D_F00D, 1'b0, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 32'h600D_F00D, 1'b0, 0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 32'h1234_5678, 1'b0, 0, 1'b0};

    // Reset held with a read pending; capture must happen on the first edge after release.
    reset_n = 1'b0;
    read    = 1'b1;
    write   = 1'b0;
    address = 32'h0000_0200;
    data_in = 32'h0;
    #12;
    check_reset_outputs("reset");
    v = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 0, 1'b0};
    @(negedge clk);
    reset_n = 1'b1;
    finish_txn("rst_release", v);

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while in WAIT aborts the write to 0x10.
    v = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0};
    drive(v);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("after_abort", '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h600D_F00D, 1'b0, 0, 1'b0});

    // Reset in DONE keeps the completed write.
    v = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0077, 32'h0, 1'b0, 0, 1'b0};
    drive(v);
    waited = 0;
    while (!(rdy0 && rdy1) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("done_reached", {31'b0, rdy0 & rdy1}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("done_reset");
    write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("after_done_reset", '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0077, 1'b0, 0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
